// File: rtl/core_pkg.sv
// Opcode encodings and sequencer state type shared by the program-counter unit
// and the instruction decoder.
package core_pkg;

    localparam logic [2:0] COND_JUMP = 3'b101;   // instruction[5:3]

    localparam logic [1:0] FN_BZ  = 2'b00;       // instruction[2:1]
    localparam logic [1:0] FN_BC  = 2'b01;
    localparam logic [1:0] FN_BNZ = 2'b10;
    localparam logic [1:0] FN_BNC = 2'b11;

    localparam logic [4:0] OP_JMP = 5'b11000;    // instruction[5:1]
    localparam logic [4:0] OP_JSB = 5'b11001;    // instruction[5:1]
    localparam logic [5:0] OP_RET = 6'b111000;   // instruction[5:0]

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FAULT = 2'd2
    } seq_state_t;

endpackage

// File: rtl/return_stack.sv
// Hardware LIFO of return addresses; the stack pointer alone decides full/empty,
// and pushes on full or pops on empty leave the stack untouched.
module return_stack #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SP_W-1:0]  sp;

    assign full  = (sp == SP_W'(DEPTH));
    assign empty = (sp == '0);
    assign top   = mem[IDX_W'(sp - SP_W'(1))];

    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end
    end

    // Entry storage is don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[IDX_W'(sp)] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: resolves branches, jumps, calls and returns, owns the
// return stack, freezes under stall and latches into FAULT on stack errors.
module pc_sequencer
    import core_pkg::*;
#(
    parameter int PC_WIDTH     = 12,
    parameter int OFFSET_WIDTH = 8,
    parameter int STACK_DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              instruction,
    input  logic                    instr_valid,
    input  logic                    stall,
    input  logic                    C_out,
    input  logic                    Z_out,
    input  logic [PC_WIDTH-1:0]     jump_target,
    input  logic [OFFSET_WIDTH-1:0] branch_offset,
    output logic [PC_WIDTH-1:0]     pc,
    output logic                    branch_taken,
    output logic                    stack_overflow,
    output logic                    stack_underflow,
    output logic                    halted
);

    seq_state_t state, state_next;

    logic [PC_WIDTH-1:0]        pc_next;
    logic [PC_WIDTH-1:0]        pc_inc;
    logic signed [PC_WIDTH-1:0] offset_ext;
    logic [PC_WIDTH-1:0]        stack_top;
    logic                       stack_full, stack_empty;
    logic                       push, pop;
    logic                       set_overflow, set_underflow;
    logic                       is_cond, is_jmp, is_jsb, is_ret, cond_true;

    assign is_cond = (instruction[5:3] == COND_JUMP);
    assign is_jmp  = (instruction[5:1] == OP_JMP);
    assign is_jsb  = (instruction[5:1] == OP_JSB);
    assign is_ret  = (instruction == OP_RET);

    always_comb begin
        cond_true = 1'b0;
        case (instruction[2:1])
            FN_BZ:   cond_true = Z_out;
            FN_BC:   cond_true = C_out;
            FN_BNZ:  cond_true = !Z_out;
            default: cond_true = !C_out;
        endcase
    end

    assign pc_inc     = pc + PC_WIDTH'(1);
    assign offset_ext = {{(PC_WIDTH-OFFSET_WIDTH){branch_offset[OFFSET_WIDTH-1]}}, branch_offset};

    return_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (stack_top),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        push          = 1'b0;
        pop           = 1'b0;
        branch_taken  = 1'b0;
        set_overflow  = 1'b0;
        set_underflow = 1'b0;
        if (state != FAULT) begin
            if (stall) begin
                state_next = STALL;
            end else begin
                state_next = RUN;
                if (instr_valid) begin
                    if (is_cond) begin
                        branch_taken = cond_true;
                        pc_next      = cond_true ? pc_inc + offset_ext : pc_inc;
                    end else if (is_jmp) begin
                        branch_taken = 1'b1;
                        pc_next      = jump_target;
                    end else if (is_jsb) begin
                        if (stack_full) begin
                            set_overflow = 1'b1;
                            state_next   = FAULT;
                        end else begin
                            push         = 1'b1;
                            branch_taken = 1'b1;
                            pc_next      = jump_target;
                        end
                    end else if (is_ret) begin
                        if (stack_empty) begin
                            set_underflow = 1'b1;
                            state_next    = FAULT;
                        end else begin
                            pop          = 1'b1;
                            branch_taken = 1'b1;
                            pc_next      = stack_top;
                        end
                    end else begin
                        pc_next = pc_inc;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= RUN;
            pc              <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            state           <= state_next;
            pc              <= pc_next;
            stack_overflow  <= stack_overflow | set_overflow;
            stack_underflow <= stack_underflow | set_underflow;
        end
    end

    assign halted = (state == FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: the driver queues the outputs expected in
// each cycle, and a monitor on the falling edge pops and compares them.
module tb_pc_sequencer;

    localparam logic [5:0] SEQ  = 6'b000000;
    localparam logic [5:0] BZ   = 6'b101000;
    localparam logic [5:0] BC   = 6'b101010;
    localparam logic [5:0] BNZ  = 6'b101100;
    localparam logic [5:0] BNC  = 6'b101110;
    localparam logic [5:0] JMP  = 6'b110000;
    localparam logic [5:0] JSB  = 6'b110010;
    localparam logic [5:0] RET  = 6'b111000;

    typedef struct packed {
        logic [15:0] tag;
        logic [11:0] pc;
        logic        bt;
        logic        ovf;
        logic        unf;
        logic        halt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  instruction;
    logic        instr_valid;
    logic        stall;
    logic        C_out;
    logic        Z_out;
    logic [11:0] jump_target;
    logic [7:0]  branch_offset;
    logic [11:0] pc;
    logic        branch_taken;
    logic        stack_overflow;
    logic        stack_underflow;
    logic        halted;

    exp_t expq[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   tag_cnt     = 0;
    logic e_ovf = 1'b0, e_unf = 1'b0, e_halt = 1'b0;

    pc_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .instruction     (instruction),
        .instr_valid     (instr_valid),
        .stall           (stall),
        .C_out           (C_out),
        .Z_out           (Z_out),
        .jump_target     (jump_target),
        .branch_offset   (branch_offset),
        .pc              (pc),
        .branch_taken    (branch_taken),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow),
        .halted          (halted)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            vectors++;
            if (pc !== e.pc || branch_taken !== e.bt || stack_overflow !== e.ovf ||
                stack_underflow !== e.unf || halted !== e.halt) begin
                miscompares++;
                $display("FAIL vec%0d: got pc=%03h bt=%0b ovf=%0b unf=%0b halt=%0b, want pc=%03h bt=%0b ovf=%0b unf=%0b halt=%0b",
                         e.tag, pc, branch_taken, stack_overflow, stack_underflow, halted,
                         e.pc, e.bt, e.ovf, e.unf, e.halt);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        instr_valid = 1'b0;
        stall = 1'b0;
        e_ovf = 1'b0;
        e_unf = 1'b0;
        e_halt = 1'b0;
    endtask

    task automatic step(input logic [5:0] ins, input logic v, input logic st,
                        input logic z, input logic c, input logic [11:0] jt,
                        input logic [7:0] off, input logic [11:0] epc, input logic ebt);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        instruction   = ins;
        instr_valid   = v;
        stall         = st;
        Z_out         = z;
        C_out         = c;
        jump_target   = jt;
        branch_offset = off;
        e.tag  = 16'(tag_cnt);
        e.pc   = epc;
        e.bt   = ebt;
        e.ovf  = e_ovf;
        e.unf  = e_unf;
        e.halt = e_halt;
        tag_cnt++;
        expq.push_back(e);
    endtask

    initial begin
        rst = 1'b1;
        instruction = SEQ;
        instr_valid = 1'b0;
        stall = 1'b0;
        C_out = 1'b0;
        Z_out = 1'b0;
        jump_target = '0;
        branch_offset = '0;

        // Reset, sequential run, idle hold, instr_valid gating branch_taken
        do_reset();
        for (int i = 0; i < 5; i++) step(SEQ, 1, 0, 0, 0, 12'h000, 8'h00, 12'(i), 0);
        step(SEQ, 0, 0, 0, 0, 12'h000, 8'h00, 12'h005, 0);
        step(BZ,  0, 0, 1, 0, 12'h000, 8'h10, 12'h005, 0);
        step(6'b111001, 1, 0, 0, 0, 12'h000, 8'h00, 12'h005, 0);

        // Conditional branches and wrap-around
        step(JMP, 1, 0, 0, 0, 12'h010, 8'h00, 12'h006, 1);
        step(BZ,  1, 0, 1, 0, 12'h000, 8'hFC, 12'h010, 1);
        step(JMP, 1, 0, 0, 0, 12'h010, 8'h00, 12'h00D, 1);
        step(BZ,  1, 0, 0, 0, 12'h000, 8'hFC, 12'h010, 0);
        step(BC,  1, 0, 0, 1, 12'h000, 8'h05, 12'h011, 1);
        step(BNZ, 1, 0, 0, 0, 12'h000, 8'h02, 12'h017, 1);
        step(BNC, 1, 0, 0, 1, 12'h000, 8'h02, 12'h01A, 0);
        step(6'b110001, 1, 0, 0, 0, 12'hFFF, 8'h00, 12'h01B, 1);
        step(SEQ, 1, 0, 0, 0, 12'h000, 8'h00, 12'hFFF, 0);
        step(SEQ, 0, 0, 0, 0, 12'h000, 8'h00, 12'h000, 0);

        // Nested call and return, then RET on the emptied stack
        step(JMP, 1, 0, 0, 0, 12'h020, 8'h00, 12'h000, 1);
        step(JSB, 1, 0, 0, 0, 12'h100, 8'h00, 12'h020, 1);
        step(JSB, 1, 0, 0, 0, 12'h200, 8'h00, 12'h100, 1);
        step(RET, 1, 0, 0, 0, 12'h000, 8'h00, 12'h200, 1);
        step(RET, 1, 0, 0, 0, 12'h000, 8'h00, 12'h101, 1);
        step(RET, 1, 0, 0, 0, 12'h000, 8'h00, 12'h021, 0);
        e_unf = 1'b1;
        e_halt = 1'b1;
        step(SEQ, 1, 0, 0, 0, 12'h000, 8'h00, 12'h021, 0);

        // Stack overflow on the ninth nested call
        do_reset();
        for (int i = 0; i < 8; i++) step(JSB, 1, 0, 0, 0, 12'((i + 1) * 16), 8'h00, 12'(i * 16), 1);
        step(JSB, 1, 0, 0, 0, 12'h090, 8'h00, 12'h080, 0);
        e_ovf = 1'b1;
        e_halt = 1'b1;
        step(SEQ, 1, 0, 0, 0, 12'h000, 8'h00, 12'h080, 0);
        step(RET, 1, 0, 0, 0, 12'h000, 8'h00, 12'h080, 0);
        step(JMP, 1, 0, 0, 0, 12'h555, 8'h00, 12'h080, 0);
        do_reset();
        step(SEQ, 1, 0, 0, 0, 12'h000, 8'h00, 12'h000, 0);

        // Underflow straight after reset
        do_reset();
        step(RET, 1, 0, 0, 0, 12'h000, 8'h00, 12'h000, 0);
        e_unf = 1'b1;
        e_halt = 1'b1;
        step(SEQ, 1, 0, 0, 0, 12'h000, 8'h00, 12'h000, 0);
        step(JMP, 1, 0, 0, 0, 12'h123, 8'h00, 12'h000, 0);

        // Stall freezes pc and the stack
        do_reset();
        step(SEQ, 1, 0, 0, 0, 12'h000, 8'h00, 12'h000, 0);
        for (int i = 0; i < 3; i++) step(JMP, 1, 1, 0, 0, 12'h300, 8'h00, 12'h001, 0);
        step(JMP, 1, 0, 0, 0, 12'h300, 8'h00, 12'h001, 1);
        step(JSB, 1, 1, 0, 0, 12'h400, 8'h00, 12'h300, 0);
        step(RET, 1, 0, 0, 0, 12'h000, 8'h00, 12'h300, 0);
        e_unf = 1'b1;
        e_halt = 1'b1;
        step(SEQ, 1, 0, 0, 0, 12'h000, 8'h00, 12'h300, 0);

        begin
            int budget;
            budget = 20;
            while (expq.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (expq.size() > 0) begin
                miscompares++;
                $display("FAIL drain: %0d expectations left, want 0", expq.size());
            end
        end
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
